// File: rtl/complex_mult_tb_pkg.sv
// Shared definitions for the complex multiplier bench agents: FSM states,
// LFSR constants and res_data field offsets, common to stimulus and checker.
package complex_mult_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DRAIN,
        ST_DONE
    } stim_state_e;

    // Fibonacci LFSR x^32 + x^22 + x^2 + x + 1, feedback taps at bits 31, 21, 1, 0
    localparam logic [31:0] LFSR_SEED = 32'hACE1_1234;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_update(input logic [31:0] s, input logic reload);
        if (reload) begin
            return LFSR_SEED;
        end
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

    // res_data layout: {tag[3:0], re[2DW-1:0], im[2DW-1:0]}
    function automatic int res_im_lsb(input int dw);
        return 0 * dw;
    endfunction

    function automatic int res_re_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int res_tag_lsb(input int dw);
        return 4 * dw;
    endfunction

endpackage

// File: rtl/complex_mult_stimulus_if.sv
// Operand and result valid/ready buses between the stimulus agent (master)
// and the complex multiplier under test (slave).
interface complex_mult_stimulus_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      op_val;
    logic                      op_ready;
    logic [4*DATA_WIDTH-1:0]   op_data;
    logic                      res_val;
    logic                      res_ready;
    logic [4*DATA_WIDTH+3:0]   res_data;

    modport master (
        output op_val, op_data, res_ready,
        input  op_ready, res_val, res_data
    );

    modport slave (
        input  op_val, op_data, res_ready,
        output op_ready, res_val, res_data
    );
endinterface

// File: rtl/cmul_stim_pattern_gen.sv
// Operand pattern source: counting pattern by default, 32-bit LFSR when
// CMUL_STIM_LFSR_EN is defined (that mode requires DATA_WIDTH <= 8).
module cmul_stim_pattern_gen
    import complex_mult_tb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    advance,
    output logic [4*DATA_WIDTH-1:0] op_data
);

`ifdef CMUL_STIM_LFSR_EN
    logic [31:0] lfsr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= '0;
        end else if (clear) begin
            lfsr <= '0;
        end else if (load || advance) begin
            lfsr <= lfsr_update(lfsr, load);
        end
    end

    assign op_data = lfsr[4*DATA_WIDTH-1:0];
`else
    logic [DATA_WIDTH-1:0]   idx;
    logic [4*DATA_WIDTH-1:0] data_q;

    function automatic logic [4*DATA_WIDTH-1:0] count_pattern(input logic [DATA_WIDTH-1:0] k);
        return {k, k + DATA_WIDTH'(1), k + DATA_WIDTH'(2), k + DATA_WIDTH'(3)};
    endfunction

    // data_q holds pattern(idx-1); idx is always the next index to present
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx    <= '0;
            data_q <= '0;
        end else if (clear) begin
            idx    <= '0;
            data_q <= '0;
        end else if (load) begin
            idx    <= DATA_WIDTH'(1);
            data_q <= count_pattern('0);
        end else if (advance) begin
            idx    <= idx + DATA_WIDTH'(1);
            data_q <= count_pattern(idx);
        end
    end

    assign op_data = data_q;
`endif

endmodule

// File: rtl/complex_mult_stimulus.sv
// Operand-side bench agent for the complex multiplier: issues NUM_TRANS operands,
// collects results, watches for timeouts. Option macro: CMUL_STIM_LFSR_EN.
module complex_mult_stimulus
    import complex_mult_tb_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_TRANS       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 256,
    parameter int RES_STALL       = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic                    start,
    complex_mult_stimulus_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err_timeout,
    output logic                    err_unexpected,
    output logic [15:0]             sent_cnt,
    output logic [15:0]             recv_cnt,
    output logic [4*DATA_WIDTH-1:0] res_sig
);

    localparam int              IM_LSB    = res_im_lsb(DATA_WIDTH);
    localparam int              TAG_LSB   = res_tag_lsb(DATA_WIDTH);
    localparam logic [15:0]     NUM_C     = 16'(NUM_TRANS);
    localparam logic [3:0]      MAX_OUT_C = 4'(MAX_OUTSTANDING);
    localparam int              WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

    stim_state_e             state, state_next;
    logic                    op_val_q, op_val_next;
    logic [15:0]             sent_next, recv_next;
    logic [3:0]              outst, outst_next;
    logic [4*DATA_WIDTH-1:0] sig_next;
    logic                    err_to_next, err_un_next;
    logic [1:0]              stall_q, stall_next;
    logic [WD_W-1:0]         wdog, wdog_next;
    logic                    active, op_hs, res_hs, counted_res, wdog_hit;
    logic                    pat_load, pat_advance;
    logic [4*DATA_WIDTH-1:0] pat_data, res_payload;
    logic                    unused_tag;

    assign active      = (state == ST_SEND) || (state == ST_DRAIN);
    assign op_hs       = op_val_q && bus.op_ready;
    assign res_hs      = bus.res_val && bus.res_ready;
    assign counted_res = res_hs && (outst != 4'd0);
    assign wdog_hit    = active && !res_hs && (outst != 4'd0) && (wdog == WD_LAST);
    assign res_payload = bus.res_data[IM_LSB +: 4*DATA_WIDTH];
    assign unused_tag  = ^bus.res_data[TAG_LSB +: 4];

    assign bus.op_val    = op_val_q;
    assign bus.op_data   = pat_data;
    assign bus.res_ready = active && !((RES_STALL != 0) && (stall_q == 2'd3));
    assign busy          = active;
    assign done          = (state == ST_DONE);

    // Next-state and next-counter logic; sw_rst overrides everything, including start
    always_comb begin
        state_next  = state;
        op_val_next = 1'b0;
        sent_next   = sent_cnt;
        recv_next   = recv_cnt;
        outst_next  = outst;
        sig_next    = res_sig;
        err_to_next = err_timeout;
        err_un_next = err_unexpected;
        stall_next  = stall_q + 2'd1;
        wdog_next   = wdog;
        pat_load    = 1'b0;
        pat_advance = 1'b0;

        if (sw_rst) begin
            state_next  = ST_IDLE;
            sent_next   = '0;
            recv_next   = '0;
            outst_next  = '0;
            sig_next    = '0;
            err_to_next = 1'b0;
            err_un_next = 1'b0;
            stall_next  = '0;
            wdog_next   = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next  = ST_SEND;
                        op_val_next = 1'b1;
                        sent_next   = '0;
                        recv_next   = '0;
                        outst_next  = '0;
                        sig_next    = '0;
                        err_to_next = 1'b0;
                        err_un_next = 1'b0;
                        stall_next  = '0;
                        wdog_next   = '0;
                        pat_load    = 1'b1;
                    end
                end
                ST_SEND, ST_DRAIN: begin
                    if (op_hs) begin
                        sent_next   = sent_cnt + 16'd1;
                        pat_advance = 1'b1;
                    end
                    if (counted_res) begin
                        recv_next = recv_cnt + 16'd1;
                        sig_next  = res_sig ^ res_payload;
                    end
                    if (res_hs && (outst == 4'd0)) begin
                        err_un_next = 1'b1;
                    end
                    outst_next = outst + {3'd0, op_hs} - {3'd0, counted_res};
                    wdog_next  = (res_hs || (outst == 4'd0)) ? '0 : wdog + WD_W'(1);

                    if (wdog_hit) begin
                        err_to_next = 1'b1;
                        state_next  = ST_DONE;
                    end else if ((state == ST_SEND) && op_hs && (sent_next == NUM_C)) begin
                        state_next = ST_DRAIN;
                    end else if ((state == ST_DRAIN) && (recv_next == NUM_C)) begin
                        state_next = ST_DONE;
                    end

                    if (!wdog_hit && (state_next == ST_SEND)) begin
                        op_val_next = (op_val_q && !bus.op_ready) ||
                                      ((sent_next < NUM_C) && (outst_next < MAX_OUT_C));
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            op_val_q       <= 1'b0;
            sent_cnt       <= '0;
            recv_cnt       <= '0;
            outst          <= '0;
            res_sig        <= '0;
            err_timeout    <= 1'b0;
            err_unexpected <= 1'b0;
            stall_q        <= '0;
            wdog           <= '0;
        end else begin
            state          <= state_next;
            op_val_q       <= op_val_next;
            sent_cnt       <= sent_next;
            recv_cnt       <= recv_next;
            outst          <= outst_next;
            res_sig        <= sig_next;
            err_timeout    <= err_to_next;
            err_unexpected <= err_un_next;
            stall_q        <= stall_next;
            wdog           <= wdog_next;
        end
    end

    cmul_stim_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern_gen (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (sw_rst),
        .load    (pat_load),
        .advance (pat_advance),
        .op_data (pat_data)
    );

endmodule

// File: tb/tb_complex_mult_stimulus.sv
// Directed bench for complex_mult_stimulus: one agent without result stall
// and one with RES_STALL=1, each answered by a small multiplier model.
`timescale 1ns/1ps
module tb_complex_mult_stimulus;
    import complex_mult_tb_pkg::*;

    localparam int DW = 8;
    localparam int NT = 16;

    typedef struct {
        logic        op_ready;
        logic        exp_op_val;
        logic [31:0] exp_op_data;
        logic [15:0] exp_sent;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        sw_rst_a, start_a, busy_a, done_a, err_to_a, err_un_a;
    logic [15:0] sent_a, recv_a;
    logic [31:0] sig_a;
    logic        sw_rst_s, start_s, busy_s, done_s, err_to_s, err_un_s;
    logic [15:0] sent_s, recv_s;
    logic [31:0] sig_s;

    complex_mult_stimulus_if #(.DATA_WIDTH(DW)) bus_a ();
    complex_mult_stimulus_if #(.DATA_WIDTH(DW)) bus_s ();

    complex_mult_stimulus #(
        .DATA_WIDTH(DW), .NUM_TRANS(NT), .MAX_OUTSTANDING(4), .TIMEOUT(256), .RES_STALL(0)
    ) u_dut_a (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst_a), .start(start_a), .bus(bus_a),
        .busy(busy_a), .done(done_a), .err_timeout(err_to_a), .err_unexpected(err_un_a),
        .sent_cnt(sent_a), .recv_cnt(recv_a), .res_sig(sig_a)
    );

    complex_mult_stimulus #(
        .DATA_WIDTH(DW), .NUM_TRANS(NT), .MAX_OUTSTANDING(4), .TIMEOUT(256), .RES_STALL(1)
    ) u_dut_s (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst_s), .start(start_s), .bus(bus_s),
        .busy(busy_s), .done(done_s), .err_timeout(err_to_s), .err_unexpected(err_un_s),
        .sent_cnt(sent_s), .recv_cnt(recv_s), .res_sig(sig_s)
    );

    function automatic logic [31:0] cmul(input logic [31:0] ops);
        logic signed [7:0]  ar, ai, br, bi;
        logic signed [15:0] re, im;
        ar = ops[31:24];
        ai = ops[23:16];
        br = ops[15:8];
        bi = ops[7:0];
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {re, im};
    endfunction

    function automatic logic [31:0] pattern(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    // Multiplier models: queue accepted operands, answer in order when enabled
    logic [31:0] q_a[$];
    logic [31:0] q_s[$];
    logic        res_en_a, force_res_a, res_en_s;

    always @(posedge clk) begin
        if (bus_a.res_val && bus_a.res_ready && q_a.size() > 0) void'(q_a.pop_front());
        if (bus_a.op_val && bus_a.op_ready) q_a.push_back(bus_a.op_data);
        if (bus_s.res_val && bus_s.res_ready && q_s.size() > 0) void'(q_s.pop_front());
        if (bus_s.op_val && bus_s.op_ready) q_s.push_back(bus_s.op_data);
    end

    always @(negedge clk) begin
        bus_a.res_val  = force_res_a || (res_en_a && q_a.size() > 0);
        bus_a.res_data = (q_a.size() > 0) ? {4'h3, cmul(q_a[0])} : {4'h5, 32'hDEAD_BEEF};
        bus_s.res_val  = res_en_s && q_s.size() > 0;
        bus_s.res_data = (q_s.size() > 0) ? {4'h6, cmul(q_s[0])} : 36'h0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus_a.op_ready = v.op_ready;
        step();
    endtask

    vec_t        vecs[12];
    logic [31:0] exp_sig;
    logic        got;

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b1, 32'h00010203, 16'd0};
        vecs[5]  = '{1'b1, 1'b1, 32'h01020304, 16'd1};
        vecs[6]  = '{1'b1, 1'b1, 32'h02030405, 16'd2};
        vecs[7]  = '{1'b0, 1'b1, 32'h02030405, 16'd2};
        vecs[8]  = '{1'b1, 1'b1, 32'h03040506, 16'd3};
        vecs[9]  = '{1'b1, 1'b0, 32'h04050607, 16'd4};
        vecs[10] = '{1'b1, 1'b0, 32'h04050607, 16'd4};
        vecs[11] = '{1'b1, 1'b0, 32'h04050607, 16'd4};

        exp_sig = '0;
        for (int k = 0; k < NT; k++) exp_sig ^= cmul(pattern(k));

        rstn = 1'b0;
        sw_rst_a = 1'b0; start_a = 1'b0; bus_a.op_ready = 1'b0;
        res_en_a = 1'b0; force_res_a = 1'b0;
        sw_rst_s = 1'b0; start_s = 1'b0; bus_s.op_ready = 1'b0; res_en_s = 1'b0;
        repeat (2) step();

        checkOutput("rst_op_val", bus_a.op_val, 0);
        checkOutput("rst_res_ready", bus_a.res_ready, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_err_timeout", err_to_a, 0);
        checkOutput("rst_err_unexpected", err_un_a, 0);
        checkOutput("rst_op_data", bus_a.op_data, 0);
        checkOutput("rst_sent", sent_a, 0);
        checkOutput("rst_recv", recv_a, 0);
        checkOutput("rst_sig", sig_a, 0);
        rstn = 1'b1;
        step();

        // Start latency, then back-pressure and outstanding limit table
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checkOutput("start_op_val", bus_a.op_val, 1);
        checkOutput("start_op_data", bus_a.op_data, 32'h00010203);
        checkOutput("start_busy", busy_a, 1);
        checkOutput("start_res_ready", bus_a.res_ready, 1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_op_val", i), bus_a.op_val, vecs[i].exp_op_val);
            checkOutput($sformatf("vec%0d_op_data", i), bus_a.op_data, vecs[i].exp_op_data);
            checkOutput($sformatf("vec%0d_sent", i), sent_a, vecs[i].exp_sent);
        end

        // First result frees one slot; sent stays 4 until now
        res_en_a = 1'b1;
        step();
        checkOutput("first_res_recv", recv_a, 1);
        checkOutput("first_res_sig", sig_a, 32'hFFFD0002);
        checkOutput("first_res_sent", sent_a, 4);
        checkOutput("first_res_op_val", bus_a.op_val, 1);

        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            step();
            if (recv_a == 16'(NT)) got = 1'b1;
        end
        checkOutput("run_complete", got, 1);
        checkOutput("done_after_last_result", done_a, 1);
        checkOutput("run_sent", sent_a, NT);
        checkOutput("run_sig", sig_a, exp_sig);
        checkOutput("run_err_timeout", err_to_a, 0);
        checkOutput("run_err_unexpected", err_un_a, 0);
        checkOutput("run_op_val_idle", bus_a.op_val, 0);
        step();
        checkOutput("done_holds", done_a, 1);
        checkOutput("done_res_ready", bus_a.res_ready, 0);

        // Watchdog abort while an operand is still waiting on op_ready
        q_a.delete();
        res_en_a = 1'b0;
        bus_a.op_ready = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checkOutput("to_restart_busy", busy_a, 1);
        checkOutput("to_restart_sent", sent_a, 0);
        step();
        bus_a.op_ready = 1'b0;
        checkOutput("to_first_sent", sent_a, 1);
        repeat (255) step();
        checkOutput("to_before_expiry", err_to_a, 0);
        checkOutput("to_before_op_val", bus_a.op_val, 1);
        step();
        checkOutput("to_err_timeout", err_to_a, 1);
        checkOutput("to_done", done_a, 1);
        checkOutput("to_busy", busy_a, 0);
        checkOutput("to_op_val_dropped", bus_a.op_val, 0);
        checkOutput("to_sent", sent_a, 1);

        // Unexpected result while nothing is outstanding
        q_a.delete();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checkOutput("un_err_timeout_cleared", err_to_a, 0);
        force_res_a = 1'b1;
        step();
        force_res_a = 1'b0;
        checkOutput("un_err_unexpected", err_un_a, 1);
        checkOutput("un_recv", recv_a, 0);
        checkOutput("un_sig", sig_a, 0);
        checkOutput("un_op_data_held", bus_a.op_data, 32'h00010203);

        // Soft reset mid-run wins over a simultaneous start
        sw_rst_a = 1'b1;
        start_a = 1'b1;
        step();
        checkOutput("swr_op_val", bus_a.op_val, 0);
        checkOutput("swr_op_data", bus_a.op_data, 0);
        checkOutput("swr_busy", busy_a, 0);
        checkOutput("swr_done", done_a, 0);
        checkOutput("swr_err_unexpected", err_un_a, 0);
        checkOutput("swr_res_ready", bus_a.res_ready, 0);
        checkOutput("swr_sent", sent_a, 0);
        checkOutput("swr_recv", recv_a, 0);
        checkOutput("swr_sig", sig_a, 0);
        sw_rst_a = 1'b0;
        start_a = 1'b0;
        q_a.delete();
        step();
        checkOutput("swr_stays_idle", busy_a, 0);

        // Periodic result stall: res_ready low on every 4th cycle of the run
        bus_s.op_ready = 1'b1;
        res_en_s = 1'b1;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (busy_s) begin
                checkOutput($sformatf("stall_res_ready_c%0d", i), bus_s.res_ready, (i % 4) != 3);
                step();
            end else begin
                got = 1'b1;
            end
        end
        checkOutput("stall_run_complete", got, 1);
        checkOutput("stall_done", done_s, 1);
        checkOutput("stall_recv", recv_s, NT);
        checkOutput("stall_sent", sent_s, NT);
        checkOutput("stall_sig", sig_s, exp_sig);
        checkOutput("stall_err_timeout", err_to_s, 0);
        checkOutput("stall_err_unexpected", err_un_s, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
